// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and default sizes for the serializer front end
package seq_det_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock word FIFO with registered occupancy count
module sync_fifo
  import seq_det_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Pushes into a full FIFO and pops from an empty one are silently dropped.
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - buffered parallel-to-serial converter with gapless word reload
module bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(WIDTH);

  ser_state_t       state;
  ser_state_t       next_state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             last_bit;
  logic             pop;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .push   (in_valid),
    .pop    (pop),
    .wr_data(in_data),
    .rd_data(fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign last_bit      = (bit_cnt == CNT_W'(WIDTH-1));
  // Reload happens on the edge that retires the final bit, so words run back to back.
  assign pop           = !flush && !fifo_empty &&
                         ((state == SER_IDLE) || ((state == SER_SHIFT) && last_bit));
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SER_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = SER_IDLE;
    end else begin
      case (state)
        SER_IDLE:  if (!fifo_empty) next_state = SER_SHIFT;
        SER_SHIFT: if (last_bit && fifo_empty) next_state = SER_IDLE;
        default:   next_state = SER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      shreg   <= fifo_head;
      bit_cnt <= '0;
    end else if (state == SER_SHIFT) begin
      shreg   <= shreg_shifted;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ser_valid = (state == SER_SHIFT);
    ser_out   = ser_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    busy      = !fifo_empty || ser_valid;
    in_ready  = !fifo_full;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - scoreboard bench driving MSB-first and LSB-first serializers in parallel
module tb_bit_serializer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;

  logic         in_ready_m, ser_out_m, ser_valid_m, busy_m;
  logic [2:0]   fifo_count_m;
  logic         in_ready_l, ser_out_l, ser_valid_l, busy_l;
  logic [2:0]   fifo_count_l;

  typedef struct {
    string name;
    int    sel;
    int    exp;
    int    act;
  } chk_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   q_m[$];
  bit   q_l[$];
  chk_t dq[$];
  int   kill_cnt = 0;
  int   seen_kill = 0;
  int   pend = 0;

  bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m), .busy(busy_m),
    .fifo_count(fifo_count_m)
  );

  bit_serializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l), .busy(busy_l),
    .fifo_count(fifo_count_l)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: every accepted word contributes its bits in wire order.
  always @(posedge clk) begin
    if (reset || flush) begin
      q_m.delete();
      q_l.delete();
      kill_cnt++;
    end else if (in_valid && in_ready_m) begin
      for (int i = W-1; i >= 0; i--) q_m.push_back(in_data[i]);
      for (int i = 0; i < W; i++) q_l.push_back(in_data[i]);
    end
  end

  // Monitor: a bit must be on the wire exactly when unsent bits were pending one cycle earlier.
  always @(negedge clk) begin
    chk_t c;
    bit   exp_v;
    int   act;
    while (dq.size() > 0) begin
      c = dq.pop_front();
      case (c.sel)
        0:       act = int'(in_ready_m);
        1:       act = int'(ser_valid_m);
        2:       act = int'(ser_out_m);
        3:       act = int'(busy_m);
        4:       act = int'(fifo_count_m);
        default: act = c.act;
      endcase
      check(c.name, act, c.exp);
    end
    exp_v = (pend > 0) && (kill_cnt == seen_kill);
    seen_kill = kill_cnt;
    check("ser_valid_msb", int'(ser_valid_m), int'(exp_v));
    check("ser_valid_lsb", int'(ser_valid_l), int'(exp_v));
    if (ser_valid_m) begin
      if (q_m.size() == 0) check("unexpected_bit_msb", 1, 0);
      else check("ser_out_msb", int'(ser_out_m), int'(q_m.pop_front()));
    end else begin
      check("idle_out_msb", int'(ser_out_m), 0);
    end
    if (ser_valid_l) begin
      if (q_l.size() == 0) check("unexpected_bit_lsb", 1, 0);
      else check("ser_out_lsb", int'(ser_out_l), int'(q_l.pop_front()));
    end else begin
      check("idle_out_lsb", int'(ser_out_l), 0);
    end
    check("in_ready_vs_count", int'(in_ready_m), int'(fifo_count_m < 3'(D)));
    check("count_bound", int'(fifo_count_m <= 3'(D)), 1);
    check("busy_rule", int'(busy_m), int'((fifo_count_m != 0) || ser_valid_m));
    check("count_match_lsb", int'(fifo_count_l), int'(fifo_count_m));
    pend = q_m.size();
  end

  task automatic req(input string name, input int sel, input int exp, input int act = 0);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    c.act  = act;
    dq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w, output int waits);
    in_valid = 1'b1;
    in_data  = w;
    waits    = 0;
    while (!in_ready_m && waits < 200) begin
      step();
      waits++;
    end
    req("push_timeout", 5, 1, int'(in_ready_m));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy_m || q_m.size() != 0) && n < 500) begin
      step();
      n++;
    end
    req("drain_done", 5, 0, int'(busy_m));
    step();
  endtask

  task automatic expect_reset_outputs(input string tag);
    req({tag, "_in_ready"}, 0, 1);
    req({tag, "_ser_valid"}, 1, 0);
    req({tag, "_ser_out"}, 2, 0);
    req({tag, "_busy"}, 3, 0);
    req({tag, "_fifo_count"}, 4, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int           w;
    int           r;
    logic [W-1:0] b2b [4];
    b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'hFF; b2b[3] = 8'h01;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    step(); step();
    in_valid = 1'b1;
    expect_reset_outputs("in_reset");
    step();
    in_valid = 1'b0;
    reset = 1'b0;
    expect_reset_outputs("after_reset");
    step();

    push_word(8'hD0, w);
    drain();

    for (int i = 0; i < 4; i++) begin
      push_word(b2b[i], w);
      req("b2b_stall", 5, 0, w);
    end
    drain();

    push_word(8'h11, w);
    push_word(8'h22, w);
    push_word(8'h33, w);
    push_word(8'h44, w);
    push_word(8'h55, w);
    req("full_count", 4, 4);
    req("full_in_ready", 0, 0);
    req("full_busy", 3, 1);
    push_word(8'h66, w);
    req("full_wait_cycles", 5, 5, w);
    drain();

    push_word(8'hF0, w);
    push_word(8'h5A, w);
    step(); step();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    req("flush_count", 4, 0);
    req("flush_ser_valid", 1, 0);
    req("flush_busy", 3, 0);
    repeat (12) step();

    push_word(8'hC3, w);
    push_word(8'h96, w);
    push_word(8'h3E, w);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_reset_outputs("mid_reset");
    repeat (3) step();
    push_word(8'h0D, w);
    drain();

    push_word(8'h0B, w);
    drain();

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        push_word(W'($urandom), w);
      end else if (r < 70) begin
        repeat ($urandom_range(1, 5)) step();
      end else if (r < 75) begin
        flush = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data = W'($urandom);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        req("rand_flush_count", 4, 0);
      end else if (r < 77) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_reset_outputs("rand_reset");
      end else begin
        step();
      end
    end
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
